// File: rtl/dt_engine_pkg.sv
// Shared types and helpers for the two-pass distance-transform engine.
package dt_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FW_FETCH,
        FW_RD,
        FW_WR,
        FW_END,
        BW_RD,
        BW_WR,
        DONE
    } dt_state_e;

    localparam logic METRIC_CHESS = 1'b0;
    localparam logic METRIC_CITY  = 1'b1;

    // Neighbour lanes that take part in the min. Forward lanes are
    // W, NW, N, NE; backward lanes are E, SW, S, SE. City-block keeps
    // only the orthogonal pair in either direction.
    localparam logic [3:0] LANES_CHESS = 4'b1111;
    localparam logic [3:0] LANES_CITY  = 4'b0101;

    function automatic int dt_res_aw(input int img_w, input int img_h);
        return $clog2(img_w * img_h);
    endfunction

    function automatic int dt_sti_aw(input int img_w, input int img_h, input int sti_w);
        return $clog2(img_w * img_h / sti_w);
    endfunction

endpackage

// File: rtl/dt_min_sat.sv
// Saturating min-plus-one: lanes 0..3 are neighbours that get +1
// (clamped at all-ones), lane 4 is the pixel's own value taken as-is.
// Lanes with valid low are ignored.
module dt_min_sat #(
    parameter int DIST_W = 8
) (
    input  logic [4:0][DIST_W-1:0] op_i,
    input  logic [4:0]             valid_i,
    output logic [DIST_W-1:0]      res_o
);

    logic [DIST_W-1:0] nb_min;
    logic [DIST_W-1:0] nb_inc;

    // Min over valid neighbours, then saturating increment, then min with self.
    always_comb begin
        nb_min = '1;
        for (int i = 0; i < 4; i++) begin
            if (valid_i[i] && (op_i[i] < nb_min)) begin
                nb_min = op_i[i];
            end
        end
        nb_inc = (nb_min == '1) ? nb_min : nb_min + 1'b1;
        res_o  = nb_inc;
        if (valid_i[4] && (op_i[4] < nb_inc)) begin
            res_o = op_i[4];
        end
    end

endmodule

// File: rtl/dt_engine.sv
// Two-pass distance transform: forward raster pass from the binary ROM
// into the result RAM, then a reverse raster refinement pass in place.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | waiting for start after reset
//   FW_FETCH | read one ROM word (STI_W pixels) into the shift register
//   FW_RD    | one neighbour read per cycle (W, NW, N, NE) for an object pixel
//   FW_WR    | write forward value (0 for background), advance pixel
//   FW_END   | one-cycle fwpass_finish pulse
//   BW_RD    | lane 0 reads the pixel itself; lanes 1..4 read E, SW, S, SE
//   BW_WR    | write refined value, step back one pixel
//   DONE     | done held high until the next start
module dt_engine
    import dt_engine_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int STI_W  = 16,
    parameter int DIST_W = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      metric,
    output logic                                      sti_rd,
    output logic [dt_sti_aw(IMG_W, IMG_H, STI_W)-1:0] sti_addr,
    input  logic [STI_W-1:0]                          sti_di,
    output logic                                      res_rd,
    output logic                                      res_wr,
    output logic [dt_res_aw(IMG_W, IMG_H)-1:0]        res_addr,
    output logic [DIST_W-1:0]                         res_do,
    input  logic [DIST_W-1:0]                         res_di,
    output logic                                      fwpass_finish,
    output logic                                      done
);

    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int AW   = RW + CW;
    localparam int SA_W = dt_sti_aw(IMG_W, IMG_H, STI_W);
    localparam int SB   = $clog2(STI_W);

    dt_state_e                state_q, state_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic [2:0]               lane_q, lane_d;
    logic                     metric_q, metric_d;
    logic [STI_W-1:0]         word_q, word_d;
    logic [3:0][DIST_W-1:0]   nb_q, nb_d;
    logic [DIST_W-1:0]        self_q, self_d;

    logic [RW-1:0]            row_m1, row_p1;
    logic [CW-1:0]            col_m1, col_p1;
    logic [AW-1:0]            pix_addr, nb_addr;
    logic                     nb_in, bw;
    logic [1:0]               li;
    logic [3:0]               lane_mask;
    logic                     first_pix, last_pix;
    logic [DIST_W-1:0]        min_res;

    assign row_m1    = row_q - 1'b1;
    assign row_p1    = row_q + 1'b1;
    assign col_m1    = col_q - 1'b1;
    assign col_p1    = col_q + 1'b1;
    assign pix_addr  = {row_q, col_q};
    assign first_pix = (row_q == '0) && (col_q == '0);
    assign last_pix  = &{row_q, col_q};
    assign lane_mask = (metric_q == METRIC_CITY) ? LANES_CITY : LANES_CHESS;

    // Neighbour address and in-image test for the current lane; lanes
    // outside the image read as 0 and never touch the RAM.
    always_comb begin
        bw      = (state_q == BW_RD);
        li      = bw ? (lane_q[1:0] - 2'd1) : lane_q[1:0];
        nb_addr = '0;
        nb_in   = 1'b0;
        if (!bw) begin
            case (li)
                2'd0:    begin nb_addr = {row_q,  col_m1}; nb_in = (col_q != '0); end
                2'd1:    begin nb_addr = {row_m1, col_m1}; nb_in = (row_q != '0) && (col_q != '0); end
                2'd2:    begin nb_addr = {row_m1, col_q};  nb_in = (row_q != '0); end
                default: begin nb_addr = {row_m1, col_p1}; nb_in = (row_q != '0) && !(&col_q); end
            endcase
        end else begin
            case (li)
                2'd0:    begin nb_addr = {row_q,  col_p1}; nb_in = !(&col_q); end
                2'd1:    begin nb_addr = {row_p1, col_m1}; nb_in = !(&row_q) && (col_q != '0); end
                2'd2:    begin nb_addr = {row_p1, col_q};  nb_in = !(&row_q); end
                default: begin nb_addr = {row_p1, col_p1}; nb_in = !(&row_q) && !(&col_q); end
            endcase
        end
    end

    dt_min_sat #(
        .DIST_W (DIST_W)
    ) u_min_sat (
        .op_i    ({self_q, nb_q}),
        .valid_i ({(state_q == BW_WR), lane_mask}),
        .res_o   (min_res)
    );

    // Next-state and memory strobes; everything idles at zero outside its state.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        lane_d        = lane_q;
        metric_d      = metric_q;
        word_d        = word_q;
        nb_d          = nb_q;
        self_d        = self_q;
        sti_rd        = 1'b0;
        sti_addr      = '0;
        res_rd        = 1'b0;
        res_wr        = 1'b0;
        res_addr      = '0;
        res_do        = '0;
        fwpass_finish = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d  = FW_FETCH;
                    row_d    = '0;
                    col_d    = '0;
                    metric_d = metric;
                end
            end
            FW_FETCH: begin
                sti_rd   = 1'b1;
                sti_addr = SA_W'(pix_addr >> SB);
                word_d   = sti_di;
                lane_d   = '0;
                state_d  = FW_RD;
            end
            FW_RD: begin
                if (!word_q[STI_W-1]) begin
                    state_d = FW_WR;
                end else begin
                    if (lane_mask[li]) begin
                        if (nb_in) begin
                            res_rd   = 1'b1;
                            res_addr = nb_addr;
                            nb_d[li] = res_di;
                        end else begin
                            nb_d[li] = '0;
                        end
                    end
                    if (lane_q == 3'd3) state_d = FW_WR;
                    else                lane_d  = lane_q + 3'd1;
                end
            end
            FW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix_addr;
                res_do   = word_q[STI_W-1] ? min_res : '0;
                word_d   = word_q << 1;
                lane_d   = '0;
                if (last_pix) begin
                    state_d = FW_END;
                end else begin
                    col_d = col_p1;
                    if (&col_q) row_d = row_p1;
                    state_d = (&col_q[SB-1:0]) ? FW_FETCH : FW_RD;
                end
            end
            FW_END: begin
                fwpass_finish = 1'b1;
                lane_d        = '0;
                state_d       = BW_RD;
            end
            BW_RD: begin
                if (lane_q == '0) begin
                    res_rd   = 1'b1;
                    res_addr = pix_addr;
                    if (res_di == '0) begin
                        if (first_pix) begin
                            state_d = DONE;
                        end else begin
                            col_d = col_m1;
                            if (col_q == '0) row_d = row_m1;
                        end
                    end else begin
                        self_d = res_di;
                        lane_d = 3'd1;
                    end
                end else begin
                    if (lane_mask[li]) begin
                        if (nb_in) begin
                            res_rd   = 1'b1;
                            res_addr = nb_addr;
                            nb_d[li] = res_di;
                        end else begin
                            nb_d[li] = '0;
                        end
                    end
                    if (lane_q == 3'd4) state_d = BW_WR;
                    else                lane_d  = lane_q + 3'd1;
                end
            end
            BW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix_addr;
                res_do   = min_res;
                lane_d   = '0;
                if (first_pix) begin
                    state_d = DONE;
                end else begin
                    col_d = col_m1;
                    if (col_q == '0) row_d = row_m1;
                    state_d = BW_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            lane_q   <= '0;
            metric_q <= METRIC_CHESS;
            word_q   <= '0;
            nb_q     <= '0;
            self_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            lane_q   <= lane_d;
            metric_q <= metric_d;
            word_q   <= word_d;
            nb_q     <= nb_d;
            self_q   <= self_d;
        end
    end

endmodule

// File: tb/tb_dt_engine.sv
// Directed bench for dt_engine: 16x16 images, one 8-bit and one 3-bit instance.
module tb_dt_engine;

    localparam int BUDGET = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start3 = 1'b0, metric = 1'b0;
    logic        sti_rd8, res_rd8, res_wr8, fwf8, done8;
    logic        sti_rd3, res_rd3, res_wr3, fwf3, done3;
    logic [3:0]  sti_addr8, sti_addr3;
    logic [7:0]  res_addr8, res_addr3;
    logic [15:0] sti_di8 = '0, sti_di3 = '0;
    logic [7:0]  res_do8, res_di8 = '0;
    logic [2:0]  res_do3, res_di3 = '0;

    logic [15:0] rom  [16];
    logic [7:0]  ram8 [256];
    logic [2:0]  ram3 [256];

    int n_tests = 0, n_fail = 0;
    int fw8 = 0, fw3 = 0, dr8 = 0, dr3 = 0, fwd8 = 0, fwd3 = 0, st8 = 0, st3 = 0, ovl = 0;
    logic done8_p = 1'b0, done3_p = 1'b0;

    always #5 clk = ~clk;

    dt_engine #(.IMG_W(16), .IMG_H(16), .STI_W(16), .DIST_W(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .metric(metric),
        .sti_rd(sti_rd8), .sti_addr(sti_addr8), .sti_di(sti_di8),
        .res_rd(res_rd8), .res_wr(res_wr8), .res_addr(res_addr8),
        .res_do(res_do8), .res_di(res_di8),
        .fwpass_finish(fwf8), .done(done8)
    );

    dt_engine #(.IMG_W(16), .IMG_H(16), .STI_W(16), .DIST_W(3)) u_dut3 (
        .clk(clk), .reset(rst), .start(start3), .metric(metric),
        .sti_rd(sti_rd3), .sti_addr(sti_addr3), .sti_di(sti_di3),
        .res_rd(res_rd3), .res_wr(res_wr3), .res_addr(res_addr3),
        .res_do(res_do3), .res_di(res_di3),
        .fwpass_finish(fwf3), .done(done3)
    );

    // Negedge-read memories.
    always @(negedge clk) begin
        if (sti_rd8) sti_di8 <= rom[sti_addr8];
        if (sti_rd3) sti_di3 <= rom[sti_addr3];
        if (res_rd8) res_di8 <= ram8[res_addr8];
        if (res_rd3) res_di3 <= ram3[res_addr3];
    end

    always @(posedge clk) begin
        if (res_wr8) ram8[res_addr8] <= res_do8;
        if (res_wr3) ram3[res_addr3] <= res_do3;
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fwf8) fw8 <= fw8 + 1;
        if (fwf3) fw3 <= fw3 + 1;
        if (sti_rd8) st8 <= st8 + 1;
        if (sti_rd3) st3 <= st3 + 1;
        if (done8 && !done8_p) begin dr8 <= dr8 + 1; fwd8 <= fw8; end
        if (done3 && !done3_p) begin dr3 <= dr3 + 1; fwd3 <= fw3; end
        done8_p <= done8;
        done3_p <= done3;
        if ((res_rd8 && res_wr8) || (res_rd3 && res_wr3)) ovl <= ovl + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic img_clear();
        for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
    endtask

    task automatic img_fill();
        for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
    endtask

    task automatic img_pix(input int r, input int c, input logic v);
        rom[r][15-c] = v;
    endtask

    task automatic img_block();
        img_clear();
        for (int r = 4; r <= 8; r++)
            for (int c = 4; c <= 8; c++) img_pix(r, c, 1'b1);
    endtask

    function automatic int d8(input int r, input int c);
        return int'(ram8[r*16+c]);
    endfunction

    function automatic int d3(input int r, input int c);
        return int'(ram3[r*16+c]);
    endfunction

    function automatic int nz8_except(input int idx);
        int cnt = 0;
        for (int i = 0; i < 256; i++) if (i != idx && ram8[i] != 8'd0) cnt++;
        return cnt;
    endfunction

    task automatic run_dt(input int sel, input logic m, input string tag);
        int fw0, dr0, st0, n;
        logic dn;
        fw0 = (sel == 1) ? fw3 : fw8;
        dr0 = (sel == 1) ? dr3 : dr8;
        st0 = (sel == 1) ? st3 : st8;
        @(negedge clk);
        metric = m;
        if (sel == 1) start3 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        start3 = 1'b0;
        check_eq({tag, "_done_clr"}, int'((sel == 1) ? done3 : done8), 0);
        n  = 0;
        dn = (sel == 1) ? done3 : done8;
        while (!dn && n < BUDGET) begin
            @(negedge clk);
            n++;
            dn = (sel == 1) ? done3 : done8;
        end
        check_eq({tag, "_done"}, int'(dn), 1);
        repeat (3) @(negedge clk);
        check_eq({tag, "_held"}, int'((sel == 1) ? done3 : done8), 1);
        check_eq({tag, "_fwpass"}, ((sel == 1) ? fw3 : fw8) - fw0, 1);
        check_eq({tag, "_fw_before_done"}, ((sel == 1) ? fwd3 : fwd8) - fw0, 1);
        check_eq({tag, "_done_rise"}, ((sel == 1) ? dr3 : dr8) - dr0, 1);
        check_eq({tag, "_sti_words"}, ((sel == 1) ? st3 : st8) - st0, 16);
    endtask

    initial begin
        int fw0, dr0, n;

        img_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_sti_rd", int'(sti_rd8), 0);
        check_eq("rst_res_rd", int'(res_rd8), 0);
        check_eq("rst_res_wr", int'(res_wr8), 0);
        check_eq("rst_fwpass", int'(fwf8), 0);
        check_eq("rst_done", int'(done8), 0);
        check_eq("rst_res_addr", int'(res_addr8), 0);
        check_eq("rst_sti_addr", int'(sti_addr8), 0);
        check_eq("rst_res_do", int'(res_do8), 0);
        rst = 1'b0;

        // Full image with a single hole at (8,8)
        img_fill();
        img_pix(8, 8, 1'b0);
        run_dt(0, 1'b0, "hole_chess");
        check_eq("hole_chess_9_9", d8(9, 9), 1);
        check_eq("hole_chess_8_8", d8(8, 8), 0);
        check_eq("hole_chess_0_0", d8(0, 0), 1);
        check_eq("hole_chess_15_15", d8(15, 15), 1);
        check_eq("hole_chess_3_12", d8(3, 12), 4);
        run_dt(0, 1'b1, "hole_city");
        check_eq("hole_city_9_9", d8(9, 9), 2);
        check_eq("hole_city_8_9", d8(8, 9), 1);
        check_eq("hole_city_3_12", d8(3, 12), 4);

        // 5x5 block at rows/cols 4..8
        img_block();
        run_dt(0, 1'b0, "blk_chess");
        check_eq("blk_chess_6_6", d8(6, 6), 3);
        check_eq("blk_chess_5_5", d8(5, 5), 2);
        check_eq("blk_chess_4_4", d8(4, 4), 1);
        check_eq("blk_chess_4_6", d8(4, 6), 1);
        check_eq("blk_chess_8_8", d8(8, 8), 1);
        check_eq("blk_chess_3_3", d8(3, 3), 0);
        run_dt(0, 1'b1, "blk_city");
        check_eq("blk_city_6_6", d8(6, 6), 3);
        check_eq("blk_city_5_5", d8(5, 5), 2);
        check_eq("blk_city_4_4", d8(4, 4), 1);
        check_eq("blk_city_4_6", d8(4, 6), 1);
        check_eq("blk_city_5_6", d8(5, 6), 2);

        // Reset in the middle of a forward pass, then a clean rerun
        img_clear();
        img_pix(5, 5, 1'b1);
        fw0 = fw8;
        @(negedge clk);
        metric = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_strobes", int'({sti_rd8, res_rd8, res_wr8, fwf8, done8}), 0);
        check_eq("midrst_res_addr", int'(res_addr8), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_no_fwpass", fw8 - fw0, 0);
        run_dt(0, 1'b0, "one_chess");
        check_eq("one_chess_85", d8(5, 5), 1);
        check_eq("one_chess_others", nz8_except(85), 0);
        run_dt(0, 1'b1, "one_city");
        check_eq("one_city_85", d8(5, 5), 1);
        check_eq("one_city_others", nz8_except(85), 0);

        // Narrow distance width saturates
        img_fill();
        run_dt(1, 1'b0, "sat");
        check_eq("sat_7_7", d3(7, 7), 7);
        check_eq("sat_8_8", d3(8, 8), 7);
        check_eq("sat_0_0", d3(0, 0), 1);
        check_eq("sat_2_5", d3(2, 5), 3);
        check_eq("sat_15_15", d3(15, 15), 1);

        // start during the backward pass is ignored
        img_block();
        fw0 = fw8;
        dr0 = dr8;
        @(negedge clk);
        metric = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (fw8 == fw0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("bwstart_fwpass_seen", fw8 - fw0, 1);
        repeat (10) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("bwstart_done", int'(done8), 1);
        repeat (30) @(negedge clk);
        check_eq("bwstart_done_held", int'(done8), 1);
        check_eq("bwstart_done_rise", dr8 - dr0, 1);
        check_eq("bwstart_single_fw", fw8 - fw0, 1);
        check_eq("bwstart_6_6", d8(6, 6), 3);
        check_eq("bwstart_5_5", d8(5, 5), 2);
        check_eq("bwstart_4_6", d8(4, 6), 1);

        check_eq("rd_wr_exclusive", ovl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
